// File: rtl/chimera_cluster_pwr_seq.sv
// Shared round-robin power sequencer for the external clusters: drives isolation,
// reset and clock gate of one cluster at a time in a fixed on/off order.
module chimera_cluster_pwr_seq #(
    parameter int NumClusters   = 5,
    parameter int ClkDelay      = 2,
    parameter int RstDelay      = 4,
    parameter int TimeoutCycles = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] en_req_i,
    input  logic [NumClusters-1:0] isolated_i,
    input  logic [NumClusters-1:0] err_clr_i,
    output logic [NumClusters-1:0] clk_en_o,
    output logic [NumClusters-1:0] cluster_rst_no,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] status_o,
    output logic                   busy_o,
    output logic [NumClusters-1:0] err_o
);

    localparam int IW   = (NumClusters > 1) ? $clog2(NumClusters) : 1;
    localparam int MaxA = (ClkDelay > RstDelay) ? ClkDelay : RstDelay;
    localparam int MaxD = (MaxA > TimeoutCycles) ? MaxA : TimeoutCycles;
    localparam int CW   = $clog2(MaxD + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISO     = 3'd1;
    localparam logic [2:0] ST_RST_ON  = 3'd2;
    localparam logic [2:0] ST_CLK_OFF = 3'd3;
    localparam logic [2:0] ST_CLK_ON  = 3'd4;
    localparam logic [2:0] ST_RST_OFF = 3'd5;
    localparam logic [2:0] ST_DEISO   = 3'd6;

    logic [2:0]             state_r;
    logic [IW-1:0]          g_r;
    logic [IW-1:0]          ptr_r;
    logic [CW-1:0]          cnt_r;
    logic [NumClusters-1:0] clk_en_r;
    logic [NumClusters-1:0] rst_n_r;
    logic [NumClusters-1:0] iso_r;
    logic [NumClusters-1:0] status_r;
    logic [NumClusters-1:0] err_r;
    logic                   busy_r;

    logic [NumClusters-1:0] pend_s;
    logic [NumClusters-1:0] err_set_s;
    logic [IW-1:0]          grant_idx_s;
    logic [IW-1:0]          cand_s;
    logic [IW-1:0]          next_ptr_s;
    logic                   grant_vld_s;
    logic                   ack_s;
    logic                   clk_done_s;
    logic                   rst_done_s;
    logic                   tmo_s;

    // Round-robin grant search plus per-state completion conditions.
    always_comb begin
        pend_s      = en_req_i ^ status_r;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        for (int k = 0; k < NumClusters; k++) begin
            cand_s = IW'((int'(ptr_r) + k) % NumClusters);
            if (!grant_vld_s && pend_s[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        ack_s      = isolated_i[g_r];
        clk_done_s = (cnt_r == CW'(ClkDelay - 1));
        rst_done_s = (cnt_r == CW'(RstDelay - 1));
        tmo_s      = (cnt_r == CW'(TimeoutCycles - 1));
        next_ptr_s = (g_r == IW'(NumClusters - 1)) ? '0 : g_r + IW'(1);
        err_set_s  = '0;
        // A missing acknowledge at the last allowed count forces the sequence on.
        if (((state_r == ST_ISO) && !ack_s && tmo_s) ||
            ((state_r == ST_DEISO) && ack_s && tmo_s)) begin
            err_set_s[g_r] = 1'b1;
        end else begin
            err_set_s = '0;
        end
    end

    // Sequencer FSM and registered per-cluster outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            g_r      <= '0;
            ptr_r    <= '0;
            cnt_r    <= '0;
            clk_en_r <= '0;
            rst_n_r  <= '0;
            iso_r    <= '1;
            status_r <= '0;
            err_r    <= '0;
            busy_r   <= 1'b0;
        end else begin
            err_r <= (err_r & ~err_clr_i) | err_set_s;
            cnt_r <= cnt_r + CW'(1);
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (grant_vld_s) begin
                        g_r    <= grant_idx_s;
                        busy_r <= 1'b1;
                        if (en_req_i[grant_idx_s]) begin
                            clk_en_r[grant_idx_s] <= 1'b1;
                            state_r               <= ST_CLK_ON;
                        end else begin
                            iso_r[grant_idx_s] <= 1'b1;
                            state_r            <= ST_ISO;
                        end
                    end
                end
                ST_ISO: begin
                    if (ack_s || tmo_s) begin
                        rst_n_r[g_r] <= 1'b0;
                        cnt_r        <= '0;
                        state_r      <= ST_RST_ON;
                    end
                end
                ST_RST_ON: begin
                    if (rst_done_s) begin
                        clk_en_r[g_r] <= 1'b0;
                        cnt_r         <= '0;
                        state_r       <= ST_CLK_OFF;
                    end
                end
                ST_CLK_OFF: begin
                    if (clk_done_s) begin
                        status_r[g_r] <= 1'b0;
                        busy_r        <= 1'b0;
                        ptr_r         <= next_ptr_s;
                        cnt_r         <= '0;
                        state_r       <= ST_IDLE;
                    end
                end
                ST_CLK_ON: begin
                    if (clk_done_s) begin
                        rst_n_r[g_r] <= 1'b1;
                        cnt_r        <= '0;
                        state_r      <= ST_RST_OFF;
                    end
                end
                ST_RST_OFF: begin
                    if (rst_done_s) begin
                        iso_r[g_r] <= 1'b0;
                        cnt_r      <= '0;
                        state_r    <= ST_DEISO;
                    end
                end
                ST_DEISO: begin
                    if (!ack_s || tmo_s) begin
                        status_r[g_r] <= 1'b1;
                        busy_r        <= 1'b0;
                        ptr_r         <= next_ptr_s;
                        cnt_r         <= '0;
                        state_r       <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    assign clk_en_o       = clk_en_r;
    assign cluster_rst_no = rst_n_r;
    assign isolate_o      = iso_r;
    assign status_o       = status_r;
    assign busy_o         = busy_r;
    assign err_o          = err_r;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Directed bench for the cluster power sequencer: a checkpoint table for the basic
// up/down orderings, then hand-written sequences for timeouts, toggles and reset.
module tb_chimera_cluster_pwr_seq;

    logic       clk;
    logic       rst;
    logic [4:0] en_req;
    logic [4:0] isolated;
    logic [4:0] err_clr;
    logic [4:0] clk_en;
    logic [4:0] cl_rst_n;
    logic [4:0] isolate;
    logic [4:0] status;
    logic       busy;
    logic [4:0] err;

    int total = 0;
    int bad   = 0;

    chimera_cluster_pwr_seq dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_req_i       (en_req),
        .isolated_i     (isolated),
        .err_clr_i      (err_clr),
        .clk_en_o       (clk_en),
        .cluster_rst_no (cl_rst_n),
        .isolate_o      (isolate),
        .status_o       (status),
        .busy_o         (busy),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] en;
        logic [4:0] iso_in;
        int         adv;
        logic [4:0] clk_en;
        logic [4:0] rst_n;
        logic [4:0] iso;
        logic [4:0] status;
        logic [4:0] err;
        logic       busy;
    } vec_t;

    vec_t tbl [13];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".clk_en"}, clk_en, 5'h00);
        check({tag, ".rst_n"}, cl_rst_n, 5'h00);
        check({tag, ".iso"}, isolate, 5'h1F);
        check({tag, ".status"}, status, 5'h00);
        check({tag, ".busy"}, {4'd0, busy}, 5'h00);
        check({tag, ".err"}, err, 5'h00);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step(2);
        check_reset(tag);
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] m;
        rst      = 1'b1;
        en_req   = 5'h00;
        isolated = 5'h1F;
        err_clr  = 5'h00;

        // Cluster 0 up (T+1..T+8), cluster 2 up, then cluster 2 down with ack held high.
        tbl[0]  = '{5'h01, 5'h1F, 1, 5'h01, 5'h00, 5'h1F, 5'h00, 5'h00, 1'b1};
        tbl[1]  = '{5'h01, 5'h1F, 1, 5'h01, 5'h00, 5'h1F, 5'h00, 5'h00, 1'b1};
        tbl[2]  = '{5'h01, 5'h1F, 1, 5'h01, 5'h01, 5'h1F, 5'h00, 5'h00, 1'b1};
        tbl[3]  = '{5'h01, 5'h1F, 3, 5'h01, 5'h01, 5'h1F, 5'h00, 5'h00, 1'b1};
        tbl[4]  = '{5'h01, 5'h1F, 1, 5'h01, 5'h01, 5'h1E, 5'h00, 5'h00, 1'b1};
        tbl[5]  = '{5'h01, 5'h1E, 1, 5'h01, 5'h01, 5'h1E, 5'h01, 5'h00, 1'b0};
        tbl[6]  = '{5'h05, 5'h1E, 7, 5'h05, 5'h05, 5'h1A, 5'h01, 5'h00, 1'b1};
        tbl[7]  = '{5'h05, 5'h1A, 1, 5'h05, 5'h05, 5'h1A, 5'h05, 5'h00, 1'b0};
        tbl[8]  = '{5'h01, 5'h1E, 1, 5'h05, 5'h05, 5'h1E, 5'h05, 5'h00, 1'b1};
        tbl[9]  = '{5'h01, 5'h1E, 1, 5'h05, 5'h01, 5'h1E, 5'h05, 5'h00, 1'b1};
        tbl[10] = '{5'h01, 5'h1E, 4, 5'h01, 5'h01, 5'h1E, 5'h05, 5'h00, 1'b1};
        tbl[11] = '{5'h01, 5'h1E, 1, 5'h01, 5'h01, 5'h1E, 5'h05, 5'h00, 1'b1};
        tbl[12] = '{5'h01, 5'h1E, 1, 5'h01, 5'h01, 5'h1E, 5'h01, 5'h00, 1'b0};

        do_reset("reset");

        for (int i = 0; i < 13; i++) begin
            en_req   = tbl[i].en;
            isolated = tbl[i].iso_in;
            step(tbl[i].adv);
            check($sformatf("v%0d.clk_en", i), clk_en, tbl[i].clk_en);
            check($sformatf("v%0d.rst_n", i), cl_rst_n, tbl[i].rst_n);
            check($sformatf("v%0d.iso", i), isolate, tbl[i].iso);
            check($sformatf("v%0d.status", i), status, tbl[i].status);
            check($sformatf("v%0d.err", i), err, tbl[i].err);
            check($sformatf("v%0d.busy", i), {4'd0, busy}, {4'd0, tbl[i].busy});
        end

        // Cluster 3 up, then down with its acknowledge stuck low.
        en_req   = 5'h09;
        isolated = 5'h16;
        step(8);
        check("c3_up.status", status, 5'h09);
        en_req = 5'h01;
        step(1);
        check("c3_dn.iso", isolate, 5'h1E);
        step(254);
        check("c3_tmo255.rst_n", cl_rst_n, 5'h09);
        check("c3_tmo255.err", err, 5'h00);
        step(1);
        check("c3_tmo256.rst_n", cl_rst_n, 5'h01);
        check("c3_tmo256.err", err, 5'h08);
        step(6);
        check("c3_dn.status", status, 5'h01);
        check("c3_dn.clk_en", clk_en, 5'h01);
        check("c3_dn.busy", {4'd0, busy}, 5'h00);

        // Up with ack stuck high: clear pulse lands on the timeout cycle, set wins.
        en_req   = 5'h09;
        isolated = 5'h1E;
        step(261);
        check("c3_deiso_wait.status", status, 5'h01);
        check("c3_deiso_wait.err", err, 5'h08);
        err_clr = 5'h08;
        step(1);
        err_clr = 5'h00;
        check("set_wins.err", err, 5'h08);
        check("set_wins.status", status, 5'h09);
        err_clr = 5'h08;
        step(1);
        err_clr = 5'h00;
        check("err_clr.err", err, 5'h00);

        // Cluster 1 requested on, withdrawn during RST_OFF.
        en_req   = 5'h0B;
        isolated = 5'h14;
        step(3);
        check("c1_tog.rst_n", cl_rst_n, 5'h0B);
        en_req = 5'h09;
        step(5);
        check("c1_tog_up.status", status, 5'h0B);
        check("c1_tog_up.busy", {4'd0, busy}, 5'h00);
        step(1);
        check("c1_tog_dn.iso", isolate, 5'h16);
        check("c1_tog_dn.busy", {4'd0, busy}, 5'h01);
        isolated = 5'h16;
        step(7);
        check("c1_tog_dn.status", status, 5'h09);
        check("c1_tog_dn.clk_en", clk_en, 5'h09);
        check("c1_tog_dn.busy", {4'd0, busy}, 5'h00);

        // Reset during RST_OFF of cluster 4, then restart from CLK_ON.
        do_reset("reset2");
        en_req   = 5'h10;
        isolated = 5'h00;
        step(3);
        check("c4_rstoff.rst_n", cl_rst_n, 5'h10);
        check("c4_rstoff.clk_en", clk_en, 5'h10);
        rst = 1'b1;
        step(1);
        check_reset("midseq_reset");
        rst = 1'b0;
        step(1);
        check("c4_restart.clk_en", clk_en, 5'h10);
        check("c4_restart.rst_n", cl_rst_n, 5'h00);
        check("c4_restart.busy", {4'd0, busy}, 5'h01);
        step(7);
        check("c4_restart.status", status, 5'h10);

        // All clusters requested at once: served 0..4, one every 8 cycles.
        do_reset("reset3");
        en_req   = 5'h1F;
        isolated = 5'h00;
        for (int k = 0; k < 5; k++) begin
            m = 5'((1 << (k + 1)) - 1);
            step(1);
            check($sformatf("all%0d.clk_en", k), clk_en, m);
            check($sformatf("all%0d.pre_status", k), status, m >> 1);
            check($sformatf("all%0d.busy", k), {4'd0, busy}, 5'h01);
            step(6);
            check($sformatf("all%0d.iso", k), isolate, ~m);
            check($sformatf("all%0d.rst_n", k), cl_rst_n, m);
            step(1);
            check($sformatf("all%0d.status", k), status, m);
            check($sformatf("all%0d.idle", k), {4'd0, busy}, 5'h00);
        end
        step(2);
        check("all_done.busy", {4'd0, busy}, 5'h00);
        check("all_done.status", status, 5'h1F);
        check("all_done.err", err, 5'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chimera_cluster_pwr_seq.md
# chimera_cluster_pwr_seq

Power sequencer for the external cluster domain. It turns each cluster on or off by running a fixed order of steps: AXI isolation, cluster reset, and clock gate. One shared sequencer serves all clusters, taking pending requests in round-robin order. It sits in the SoC top next to the top-level config registers, which drive the per-cluster enable requests. Its outputs drive the per-cluster clock gates, the cluster reset inputs and the isolation cuts in front of the cluster AXI ports.

## Interface
Parameters:
- NumClusters, 5, number of sequenced clusters (one per external cluster index 0..4).
- ClkDelay, 2, cycles spent in the clock-on and clock-off states (>=1).
- RstDelay, 4, cycles spent in the reset-assert and reset-release states (>=1).
- TimeoutCycles, 255, maximum cycles to wait for the isolation acknowledge (>=1).

Ports:
- clk_i  in  1  system clock; the one clock of the block.
- rst_i  in  1  reset, synchronous, active-high.
- en_req_i  in  NumClusters  requested power state per cluster (1 = on).
- isolated_i  in  NumClusters  isolation acknowledge from each cluster's AXI isolate cut.
- err_clr_i  in  NumClusters  per-cluster clear of the sticky error bit.
- clk_en_o  out  NumClusters  per-cluster clock-gate enable.
- cluster_rst_no  out  NumClusters  per-cluster reset, active-low.
- isolate_o  out  NumClusters  per-cluster isolation request.
- status_o  out  NumClusters  current settled power state per cluster.
- busy_o  out  1  sequencer is not in IDLE.
- err_o  out  NumClusters  sticky isolation-timeout flag per cluster.

## Operation
- Reset values (all clusters off): clk_en_o=0, cluster_rst_no=0, isolate_o=all 1, status_o=0, err_o=0, busy_o=0. The FSM is in IDLE and the round-robin pointer is at 0.
- Pending vector: pend = en_req_i XOR status_o.
- In IDLE with pend != 0, the block grants the first set bit at or after the round-robin pointer, wrapping modulo NumClusters.
  - At grant it latches the cluster index `g` and the direction `up = en_req_i[g]`.
  - The pointer moves to g+1 (wrapping) on completion.
- Changes to en_req_i after the grant are ignored until the sequence completes. The cluster is then re-evaluated, so a cluster toggled mid-sequence gets a second, opposite sequence.
- Power-down sequence: ISO -> RST_ON -> CLK_OFF -> IDLE.
  - ISO: isolate_o[g]=1; stay until isolated_i[g]=1, or time out.
  - RST_ON: cluster_rst_no[g]=0 with the clock still running, for RstDelay cycles.
  - CLK_OFF: clk_en_o[g]=0, for ClkDelay cycles.
  - Completion: status_o[g]=0.
- Power-up sequence: CLK_ON -> RST_OFF -> DEISO -> IDLE.
  - CLK_ON: clk_en_o[g]=1, for ClkDelay cycles.
  - RST_OFF: cluster_rst_no[g]=1, for RstDelay cycles.
  - DEISO: isolate_o[g]=0; stay until isolated_i[g]=0, or time out.
  - Completion: status_o[g]=1.
- One counter, ceil(log2(max(ClkDelay, RstDelay, TimeoutCycles)+1)) bits wide, is cleared on every state entry.
- Timeout in ISO/DEISO: if the acknowledge is not seen by counter value TimeoutCycles-1, the block sets err_o[g] and proceeds to the next state anyway (forced isolation).
- err_o[i] stays set until err_clr_i[i]. If set and clear occur in the same cycle, set wins.
- Outputs of non-granted clusters never change during a sequence.
- rst_i mid-sequence: on the next edge every output returns to its reset value. This is an abrupt power-off of all clusters, and err_o is cleared.

## Timing
- All outputs are registered. An output changes on the clock edge that enters the state driving it.
- Grant happens on edge T (IDLE sees pend). The first sequencing state is entered at T+1, and busy_o=1 from T+1 until the last sequencing cycle.
- Wait states last exactly the parameterised cycle count. ISO and DEISO last at least 1 cycle, and isolated_i is sampled in that state.
- Power-down latency with the acknowledge already present: 2+RstDelay+ClkDelay cycles from T to status_o update. This is 8 with defaults.
- Power-up latency with the acknowledge already deasserted: 2+ClkDelay+RstDelay cycles. This is also 8 with defaults.
- Back-to-back: IDLE lasts one cycle between sequences when another cluster is pending.

## Test plan
- Reset, then en_req_i=5'b00001 and isolated_i follows isolate_o after 1 cycle -> cycle-exact ordering:
  - clk_en_o[0]=1 at T+1
  - cluster_rst_no[0]=1 at T+3
  - isolate_o[0]=0 at T+7
  - status_o[0]=1 at T+8 or later, once the acknowledge deasserts
  - err_o=0 throughout
- Cluster 2 on, then en_req_i[2]=0 with isolated_i[2] high → isolate_o[2] set at T+1, cluster_rst_no[2]=0 at T+2, clk_en_o[2]=0 at T+6, status_o[2]=0 at T+8.
- en_req_i goes 0→5'b11111 in one cycle → clusters served in order 0,1,2,3,4, one at a time, with only the granted cluster's outputs toggling; busy_o drops after the fifth completes.
- Power-down with isolated_i[3] held at 0 → ISO lasts 255 cycles, err_o[3]=1, and the sequence completes. Then err_clr_i[3] pulsed together with a fresh timeout → err_o[3] stays 1.
- en_req_i[1] toggled on→off mid power-up → the up sequence completes (status_o[1]=1), then a down sequence starts immediately.
- rst_i asserted during RST_OFF of cluster 4 → all outputs return to reset values on the next edge; after release with en_req_i unchanged, the power-up restarts from CLK_ON.
